load_store_unit: RTL and testbench

Memory-stage block directly downstream of the execute ALU. It takes the ALU result as the effective address, plus the store operand and load/store control. It issues one data-memory transaction over a req/ack bus and returns sign/zero-extended load data and the destination register to writeback. Its multi-cycle FSM holds Busy while waiting on memory so the pipeline can stall.

---
 rtl/load_store_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Memory-stage load/store unit. Takes the ALU result as the
//             effective address, issues one data-memory transaction over a
//             req/ack bus and returns the extended load data and the
//             destination tag. Busy stays high while a transaction is in
//             flight so the pipeline can stall.
//  Ports    : clk, rst (async, active-high)
//             Req_Valid/Req_Ready, Mem_Read, Mem_Write, Funct3, Addr,
//             Store_Data, Rd_In                       - request side
//             Busy, Resp_Valid, Load_Data, Rd_Out,
//             Bus_Err, Misalign                       - response side
//             DMem_Req/We/Addr/Wdata/Be, DMem_Ack/Rdata - data-memory bus
//  Options  : MISALIGN_TRAP_EN - when defined, misaligned accesses are not
//             issued and respond with Misalign = 1. When undefined, the low
//             address bits below the access size are ignored.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Mem_Read,
  input  logic        Mem_Write,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] Store_Data,
  input  logic [4:0]  Rd_In,
  output logic        Busy,
  output logic        Resp_Valid,
  output logic [31:0] Load_Data,
  output logic [4:0]  Rd_Out,
  output logic        Bus_Err,
  output logic        Misalign,
  output logic        DMem_Req,
  output logic        DMem_We,
  output logic [31:0] DMem_Addr,
  output logic [31:0] DMem_Wdata,
  output logic [3:0]  DMem_Be,
  input  logic        DMem_Ack,
  input  logic [31:0] DMem_Rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Last REQ cycle count value before the access is abandoned.
  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic        r_is_load;
  logic [4:0]  r_rd;

  // Request decode
  logic        w_load, w_store, w_ld_ok, w_st_ok, w_illegal, w_access, w_misalign;
  logic [1:0]  w_off;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic        w_issue, w_timeout;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  assign w_load  = Mem_Read & ~Mem_Write;
  assign w_store = Mem_Write & ~Mem_Read;

  always_comb begin
    w_ld_ok = 1'b0;
    w_st_ok = 1'b0;
    case (Funct3)
      3'b000, 3'b001, 3'b010: begin w_ld_ok = 1'b1; w_st_ok = 1'b1; end
      3'b100, 3'b101:         w_ld_ok = 1'b1;
      default:                ;
    endcase
  end

  assign w_illegal = (Mem_Read & Mem_Write) | (w_load & ~w_ld_ok) | (w_store & ~w_st_ok);
  assign w_access  = (w_load | w_store) & ~w_illegal;

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = w_access & (((Funct3[1:0] == 2'b01) & Addr[0]) |
                                  ((Funct3[1:0] == 2'b10) & (Addr[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  // Byte offset actually used: sub-size address bits are dropped, which only
  // matters when misaligned accesses are issued rather than trapped.
  always_comb begin
    case (Funct3[1:0])
      2'b00:   w_off = Addr[1:0];
      2'b01:   w_off = {Addr[1], 1'b0};
      default: w_off = 2'b00;
    endcase
  end

  always_comb begin
    w_wdata = Store_Data;
    w_be    = 4'b1111;
    if (w_store) begin
      case (Funct3[1:0])
        2'b00: begin
          w_wdata = {4{Store_Data[7:0]}};
          w_be    = 4'b0001 << w_off;
        end
        2'b01: begin
          w_wdata = {2{Store_Data[15:0]}};
          w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        end
        default: ;
      endcase
    end
  end

  assign w_issue   = Req_Valid & w_access & ~w_misalign;
  assign w_timeout = ~DMem_Ack & (r_cnt == c_TO_LAST);

  // Load lane extraction from the returned word
  always_comb begin
    case (r_off)
      2'd0:    w_byte = DMem_Rdata[7:0];
      2'd1:    w_byte = DMem_Rdata[15:8];
      2'd2:    w_byte = DMem_Rdata[23:16];
      default: w_byte = DMem_Rdata[31:24];
    endcase
    w_half = r_off[1] ? DMem_Rdata[31:16] : DMem_Rdata[15:0];
    case (r_f3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = DMem_Rdata;
    endcase
  end

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (Req_Valid) w_next = w_issue ? S_REQ : S_RESP;
      S_REQ:   if (DMem_Ack || w_timeout) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= 8'd0;
      r_f3       <= 3'd0;
      r_off      <= 2'd0;
      r_is_load  <= 1'b0;
      r_rd       <= 5'd0;
      DMem_We    <= 1'b0;
      DMem_Addr  <= 32'd0;
      DMem_Wdata <= 32'd0;
      DMem_Be    <= 4'd0;
      Load_Data  <= 32'd0;
      Rd_Out     <= 5'd0;
      Bus_Err    <= 1'b0;
      Misalign   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (Req_Valid) begin
          r_f3      <= Funct3;
          r_off     <= w_off;
          r_is_load <= w_load;
          r_rd      <= Rd_In;
          r_cnt     <= 8'd0;
          if (w_issue) begin
            // Bus fields only change on issue, so they are stable in REQ.
            DMem_We    <= w_store;
            DMem_Addr  <= {Addr[31:2], 2'b00};
            DMem_Wdata <= w_wdata;
            DMem_Be    <= w_be;
          end else begin
            // Immediate response: no-op, illegal or trapped misaligned.
            Load_Data <= 32'd0;
            Rd_Out    <= Rd_In;
            Bus_Err   <= w_illegal;
            Misalign  <= w_misalign;
          end
        end
        S_REQ: begin
          if (DMem_Ack) begin
            Load_Data <= r_is_load ? w_ext : 32'd0;
            Rd_Out    <= r_rd;
            Bus_Err   <= 1'b0;
            Misalign  <= 1'b0;
          end else if (w_timeout) begin
            Load_Data <= 32'd0;
            Rd_Out    <= r_rd;
            Bus_Err   <= 1'b1;
            Misalign  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Req_Ready  = (r_state == S_IDLE);
  assign Busy       = (r_state != S_IDLE);
  assign Resp_Valid = (r_state == S_RESP);
  assign DMem_Req   = (r_state == S_REQ);

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Directed self-checking bench for load_store_unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic        clk, rst;
  logic        Req_Valid, Req_Ready, Mem_Read, Mem_Write;
  logic [2:0]  Funct3;
  logic [31:0] Addr, Store_Data;
  logic [4:0]  Rd_In, Rd_Out;
  logic        Busy, Resp_Valid, Bus_Err, Misalign;
  logic [31:0] Load_Data;
  logic        DMem_Req, DMem_We, DMem_Ack;
  logic [31:0] DMem_Addr, DMem_Wdata, DMem_Rdata;
  logic [3:0]  DMem_Be;

  int checks   = 0;
  int failures = 0;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Funct3(Funct3),
    .Addr(Addr), .Store_Data(Store_Data), .Rd_In(Rd_In),
    .Busy(Busy), .Resp_Valid(Resp_Valid), .Load_Data(Load_Data),
    .Rd_Out(Rd_Out), .Bus_Err(Bus_Err), .Misalign(Misalign),
    .DMem_Req(DMem_Req), .DMem_We(DMem_We), .DMem_Addr(DMem_Addr),
    .DMem_Wdata(DMem_Wdata), .DMem_Be(DMem_Be),
    .DMem_Ack(DMem_Ack), .DMem_Rdata(DMem_Rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  `define CHK(TAG, OBS, EXP) \
    checks++; \
    assert ((OBS) === (EXP)) else begin \
      failures++; \
      $error("FAIL %s observed=%0h expected=%0h", TAG, OBS, EXP); \
    end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (Req_Ready !== ~Busy) begin
        failures++;
        $error("FAIL mon_ready observed=%0b expected=%0b", Req_Ready, ~Busy);
      end
      checks++;
      if ((Resp_Valid & ~Busy) !== 1'b0) begin
        failures++;
        $error("FAIL mon_resp_busy observed=%0b expected=0", Resp_Valid & ~Busy);
      end
      checks++;
      if ((DMem_Req & ~Busy) !== 1'b0) begin
        failures++;
        $error("FAIL mon_req_busy observed=%0b expected=0", DMem_Req & ~Busy);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] tag);
    Req_Valid  = 1'b1;
    Mem_Read   = rd;
    Mem_Write  = wr;
    Funct3     = f3;
    Addr       = a;
    Store_Data = sd;
    Rd_In      = tag;
    step();
    Req_Valid  = 1'b0;
    Mem_Read   = 1'b0;
    Mem_Write  = 1'b0;
  endtask

  task automatic ack(input logic [31:0] rdata);
    DMem_Ack   = 1'b1;
    DMem_Rdata = rdata;
    step();
    DMem_Ack   = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1; Req_Valid = 0; Mem_Read = 0; Mem_Write = 0; Funct3 = 0;
    Addr = 0; Store_Data = 0; Rd_In = 0; DMem_Ack = 0; DMem_Rdata = 0;
    step(); step();
    `CHK("rst_ready", Req_Ready, 1'b1)
    `CHK("rst_busy", Busy, 1'b0)
    `CHK("rst_req", DMem_Req, 1'b0)
    `CHK("rst_resp", Resp_Valid, 1'b0)
    `CHK("rst_ldata", Load_Data, 32'h0)
    `CHK("rst_daddr", DMem_Addr, 32'h0)
    `CHK("rst_be", DMem_Be, 4'h0)
    rst = 1'b0;
    step();

    issue(1, 0, 3'b000, 32'h1003, 32'h0, 5'd5);
    `CHK("lb_req", DMem_Req, 1'b1)
    `CHK("lb_busy", Busy, 1'b1)
    `CHK("lb_ready", Req_Ready, 1'b0)
    `CHK("lb_addr", DMem_Addr, 32'h1000)
    `CHK("lb_be", DMem_Be, 4'hF)
    `CHK("lb_we", DMem_We, 1'b0)
    step();
    `CHK("lb_noresp_early", Resp_Valid, 1'b0)
    ack(32'h80FF_1234);
    `CHK("lb_resp", Resp_Valid, 1'b1)
    `CHK("lb_data", Load_Data, 32'hFFFF_FF80)
    `CHK("lb_rd", Rd_Out, 5'd5)
    `CHK("lb_err", Bus_Err, 1'b0)
    `CHK("lb_mis", Misalign, 1'b0)
    step();
    `CHK("lb_resp_1cyc", Resp_Valid, 1'b0)
    `CHK("lb_idle", Req_Ready, 1'b1)

    issue(1, 0, 3'b101, 32'h2002, 32'h0, 5'd6);
    ack(32'hBEEF_0000);
    `CHK("lhu_resp", Resp_Valid, 1'b1)
    `CHK("lhu_data", Load_Data, 32'h0000_BEEF)
    step();
    issue(1, 0, 3'b001, 32'h2002, 32'h0, 5'd7);
    ack(32'hBEEF_0000);
    `CHK("lh_data", Load_Data, 32'hFFFF_BEEF)
    `CHK("lh_rd", Rd_Out, 5'd7)
    step();

    issue(0, 1, 3'b000, 32'h11, 32'h1234_56AB, 5'd1);
    `CHK("sb_we", DMem_We, 1'b1)
    `CHK("sb_addr", DMem_Addr, 32'h10)
    `CHK("sb_be", DMem_Be, 4'b0010)
    `CHK("sb_wdata", DMem_Wdata, 32'hABAB_ABAB)
    ack(32'hFFFF_FFFF);
    `CHK("sb_resp", Resp_Valid, 1'b1)
    `CHK("sb_ldata", Load_Data, 32'h0)
    step();

    issue(0, 1, 3'b001, 32'h22, 32'h0000_CAFE, 5'd2);
    `CHK("sh_be", DMem_Be, 4'b1100)
    `CHK("sh_wdata", DMem_Wdata, 32'hCAFE_CAFE)
    ack(32'h0);
    step();

    issue(1, 0, 3'b010, 32'h3000, 32'h0, 5'd3);
    n = 0;
    while (DMem_Req && n < 40) begin
      n++;
      step();
    end
    `CHK("to_req_cycles", n, 16)
    `CHK("to_resp", Resp_Valid, 1'b1)
    `CHK("to_err", Bus_Err, 1'b1)
    `CHK("to_ldata", Load_Data, 32'h0)
    step();
    ack(32'h1234_5678);
    `CHK("to_late_ack", Resp_Valid, 1'b0)
    step();
    `CHK("to_late_ack2", Resp_Valid, 1'b0)
    `CHK("to_ready", Req_Ready, 1'b1)

    issue(0, 1, 3'b010, 32'h6, 32'h1122_3344, 5'd4);
`ifdef MISALIGN_TRAP_EN
    `CHK("mis_noreq", DMem_Req, 1'b0)
    `CHK("mis_resp", Resp_Valid, 1'b1)
    `CHK("mis_flag", Misalign, 1'b1)
    `CHK("mis_err", Bus_Err, 1'b0)
    `CHK("mis_ldata", Load_Data, 32'h0)
`else
    `CHK("mis_req", DMem_Req, 1'b1)
    `CHK("mis_addr", DMem_Addr, 32'h4)
    `CHK("mis_be", DMem_Be, 4'hF)
    `CHK("mis_wdata", DMem_Wdata, 32'h1122_3344)
    ack(32'h0);
    `CHK("mis_resp", Resp_Valid, 1'b1)
    `CHK("mis_flag", Misalign, 1'b0)
`endif
    step();

    issue(1, 0, 3'b011, 32'h100, 32'h0, 5'd8);
    `CHK("ill_noreq", DMem_Req, 1'b0)
    `CHK("ill_resp", Resp_Valid, 1'b1)
    `CHK("ill_err", Bus_Err, 1'b1)
    `CHK("ill_rd", Rd_Out, 5'd8)
    step();

    issue(1, 1, 3'b010, 32'h100, 32'h0, 5'd9);
    `CHK("rw_noreq", DMem_Req, 1'b0)
    `CHK("rw_err", Bus_Err, 1'b1)
    step();

    issue(0, 0, 3'b000, 32'h100, 32'h0, 5'd10);
    `CHK("nop_resp", Resp_Valid, 1'b1)
    `CHK("nop_err", Bus_Err, 1'b0)
    `CHK("nop_ldata", Load_Data, 32'h0)
    step();

    issue(1, 0, 3'b010, 32'h40, 32'h0, 5'd11);
    Req_Valid = 1'b1; Mem_Read = 1'b1; Funct3 = 3'b010; Rd_In = 5'd12;
    step();
    Req_Valid = 1'b0; Mem_Read = 1'b0;
    `CHK("busy_req_held", DMem_Addr, 32'h40)
    ack(32'hDEAD_BEEF);
    `CHK("busy_resp", Resp_Valid, 1'b1)
    `CHK("busy_data", Load_Data, 32'hDEAD_BEEF)
    `CHK("busy_rd", Rd_Out, 5'd11)
    step();
    step();
    `CHK("busy_no_second", Resp_Valid, 1'b0)

    issue(1, 0, 3'b010, 32'h50, 32'h0, 5'd13);
    `CHK("ar_req_before", DMem_Req, 1'b1)
    #1 rst = 1'b1;
    #1;
    `CHK("ar_req_drop", DMem_Req, 1'b0)
    `CHK("ar_ready", Req_Ready, 1'b1)
    #1 rst = 1'b0;
    DMem_Ack = 1'b1; DMem_Rdata = 32'h5555_5555;
    step();
    DMem_Ack = 1'b0;
    `CHK("ar_noresp", Resp_Valid, 1'b0)
    step();
    `CHK("ar_noresp2", Resp_Valid, 1'b0)

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
